computie_bus_capture_controller: RTL and testbench

Sequences one computie_bus_snooper capture: arms recording, watches the record stream for a trigger and pulses the snooper's trigger input. It then stops recording after a programmed number of post-trigger records and drains the snooper into a host-side stream. It sits between the snooper's internal record interface and the comm/host logic in the comm_clock domain.

---
 rtl/computie_bus_capture_controller.sv | 166 ++++++++++++++++
 tb/tb_computie_bus_capture_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/computie_bus_capture_controller.sv
// Capture sequencer for computie_bus_snooper: arms recording, detects the trigger record,
// counts post-trigger records and drains the snooper into a one-entry host output register.
module computie_bus_capture_controller #(
  parameter int unsigned BITWIDTH    = 32,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   comm_clock,
  input  logic                   comm_reset,
  input  logic                   cmd_arm,
  input  logic                   cmd_abort,
  input  logic                   cmd_force_trigger,
  input  logic [BITWIDTH-1:0]    trig_addr,
  input  logic [BITWIDTH-1:0]    trig_mask,
  input  logic                   trig_rw,
  input  logic                   trig_rw_care,
  input  logic [COUNT_WIDTH-1:0] post_count,
  output logic                   record_start,
  output logic                   record_trigger,
  input  logic                   record_end,
  input  logic                   record_valid,
  output logic                   record_ready,
  input  logic [2*BITWIDTH:0]    record_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*BITWIDTH:0]    out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   triggered,
  output logic                   aborted,
  output logic [COUNT_WIDTH-1:0] record_count,
  output logic [COUNT_WIDTH-1:0] trig_index
);

  typedef enum logic [2:0] {StIdle, StArmed, StTriggered, StDrain, StDone} state_e;

  state_e                 r_state, w_state_next;
  logic                   r_out_valid;
  logic [2*BITWIDTH:0]    r_out_data;
  logic                   r_trig_pulse, w_trig_event;
  logic                   r_triggered, w_triggered_next;
  logic                   r_aborted, w_aborted_next;
  logic [COUNT_WIDTH-1:0] r_count, w_count_next;
  logic [COUNT_WIDTH-1:0] r_trig_index, w_trig_index_next;
  logic [COUNT_WIDTH-1:0] r_remaining, w_remaining_next;

  logic                   w_xfer;
  logic                   w_match;
  logic                   w_rw;
  logic [BITWIDTH-1:0]    w_addr;
  logic                   w_capturing;

  assign w_rw   = record_out[2*BITWIDTH];
  assign w_addr = record_out[2*BITWIDTH-1:BITWIDTH];

  assign record_ready = !r_out_valid || out_ready;
  assign w_xfer       = record_valid && record_ready;
  assign w_match      = (((w_addr ^ trig_addr) & trig_mask) == '0) &&
                        (!trig_rw_care || (w_rw == trig_rw));
  assign w_capturing  = (r_state == StArmed) || (r_state == StTriggered) || (r_state == StDrain);

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= record_out;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge comm_clock or posedge comm_reset) begin
    if (comm_reset) begin
      r_state      <= StIdle;
      r_trig_pulse <= 1'b0;
      r_triggered  <= 1'b0;
      r_aborted    <= 1'b0;
      r_count      <= '0;
      r_trig_index <= '0;
      r_remaining  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_trig_pulse <= w_trig_event;
      r_triggered  <= w_triggered_next;
      r_aborted    <= w_aborted_next;
      r_count      <= w_count_next;
      r_trig_index <= w_trig_index_next;
      r_remaining  <= w_remaining_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_trig_event      = 1'b0;
    w_triggered_next  = r_triggered;
    w_aborted_next    = r_aborted;
    w_count_next      = r_count;
    w_trig_index_next = r_trig_index;
    w_remaining_next  = r_remaining;

    // Count saturates at all-ones.
    if (w_xfer && w_capturing && (r_count != '1)) begin
      w_count_next = r_count + COUNT_WIDTH'(1);
    end

    unique case (r_state)
      StIdle, StDone: begin
        if (cmd_arm && !cmd_abort) begin
          w_state_next      = StArmed;
          w_count_next      = '0;
          w_trig_index_next = '0;
          w_triggered_next  = 1'b0;
          w_aborted_next    = 1'b0;
          w_remaining_next  = '0;
        end
      end
      StArmed: begin
        if (cmd_abort) begin
          w_state_next   = StDrain;
          w_aborted_next = 1'b1;
        end else if ((w_xfer && w_match) || cmd_force_trigger) begin
          // The matching record's index and the force-trigger index are both the pre-increment count.
          w_trig_event      = 1'b1;
          w_triggered_next  = 1'b1;
          w_trig_index_next = r_count;
          w_remaining_next  = post_count;
          w_state_next      = ((post_count == '0) || record_end) ? StDrain : StTriggered;
        end else if (record_end) begin
          w_state_next = StDrain;
        end
      end
      StTriggered: begin
        if (cmd_abort) begin
          w_state_next   = StDrain;
          w_aborted_next = 1'b1;
        end else begin
          if (w_xfer) begin
            w_remaining_next = r_remaining - COUNT_WIDTH'(1);
          end
          if (record_end || (w_xfer && (r_remaining == COUNT_WIDTH'(1)))) begin
            w_state_next = StDrain;
          end
        end
      end
      StDrain: begin
        if (record_end && !r_out_valid) begin
          w_state_next = StDone;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign record_start   = (r_state == StArmed) || (r_state == StTriggered);
  assign record_trigger = r_trig_pulse;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign busy           = w_capturing;
  assign done           = (r_state == StDone);
  assign triggered      = r_triggered;
  assign aborted        = r_aborted;
  assign record_count   = r_count;
  assign trig_index     = r_trig_index;

endmodule

// File: tb/tb_computie_bus_capture_controller.sv
// Bench for computie_bus_capture_controller: directed captures plus a randomized run, all
// checked every cycle against a behavioural capture model.
module tb_computie_bus_capture_controller;
  localparam int BW   = 32;
  localparam int CW   = 4;
  localparam int RW   = 2 * BW + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          comm_clock = 1'b0;
  logic          comm_reset;
  logic          cmd_arm, cmd_abort, cmd_force_trigger;
  logic [BW-1:0] trig_addr, trig_mask;
  logic          trig_rw, trig_rw_care;
  logic [CW-1:0] post_count;
  logic          record_start, record_trigger, record_end;
  logic          record_valid, record_ready;
  logic [RW-1:0] record_out;
  logic          out_valid, out_ready;
  logic [RW-1:0] out_data;
  logic          busy, done, triggered, aborted;
  logic [CW-1:0] record_count, trig_index;

  always #5 comm_clock = ~comm_clock;

  computie_bus_capture_controller #(.BITWIDTH(BW), .COUNT_WIDTH(CW)) dut (
    .comm_clock(comm_clock), .comm_reset(comm_reset), .cmd_arm(cmd_arm),
    .cmd_abort(cmd_abort), .cmd_force_trigger(cmd_force_trigger), .trig_addr(trig_addr),
    .trig_mask(trig_mask), .trig_rw(trig_rw), .trig_rw_care(trig_rw_care),
    .post_count(post_count), .record_start(record_start), .record_trigger(record_trigger),
    .record_end(record_end), .record_valid(record_valid), .record_ready(record_ready),
    .record_out(record_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .triggered(triggered),
    .aborted(aborted), .record_count(record_count), .trig_index(trig_index)
  );

  int total = 0;
  int bad = 0;

  // Capture model: phase 0 idle, 1 armed, 2 triggered, 3 drain, 4 done.
  int            m_phase, m_cnt, m_tidx, m_rem;
  bit            m_ov, m_pulse, m_trig, m_abt;
  logic [RW-1:0] m_od;
  bit            last_xfer;
  int            pulses;
  logic [RW-1:0] got_q[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(bit rw, logic [31:0] addr, logic [31:0] data);
    return {rw, addr, data};
  endfunction

  function automatic bit model_match(logic [RW-1:0] r);
    logic [31:0] a;
    bit          rw;
    a  = r[63:32];
    rw = r[64];
    return (((a ^ trig_addr) & trig_mask) == 0) && (!trig_rw_care || (rw == trig_rw));
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_tidx = 0; m_rem = 0;
    m_ov = 0; m_pulse = 0; m_trig = 0; m_abt = 0; m_od = '0;
  endtask

  task automatic model_step();
    bit xfer, ev;
    int nph, cnt0;
    xfer      = record_valid && (!m_ov || out_ready);
    last_xfer = xfer;
    ev        = 0;
    nph       = m_phase;
    cnt0      = m_cnt;
    if (m_phase >= 1 && m_phase <= 3 && xfer && m_cnt < CMAX) m_cnt++;
    case (m_phase)
      0, 4: if (cmd_arm && !cmd_abort) begin
        nph = 1; m_cnt = 0; m_tidx = 0; m_trig = 0; m_abt = 0; m_rem = 0;
      end
      1: begin
        if (cmd_abort) begin
          nph = 3; m_abt = 1;
        end else if ((xfer && model_match(record_out)) || cmd_force_trigger) begin
          ev = 1; m_trig = 1; m_tidx = cnt0; m_rem = int'(post_count);
          nph = (post_count == 0 || record_end) ? 3 : 2;
        end else if (record_end) nph = 3;
      end
      2: begin
        if (cmd_abort) begin
          nph = 3; m_abt = 1;
        end else begin
          if (xfer) begin
            m_rem--;
            if (m_rem == 0) nph = 3;
          end
          if (record_end) nph = 3;
        end
      end
      3: if (record_end && !m_ov) nph = 4;
      default: ;
    endcase
    m_phase = nph;
    m_pulse = ev;
    if (xfer) begin
      m_ov = 1; m_od = record_out;
    end else if (out_ready) m_ov = 0;
  endtask

  task automatic check_all();
    chk("record_start", record_start, (m_phase == 1 || m_phase == 2));
    chk("record_trigger", record_trigger, m_pulse);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("busy", busy, (m_phase >= 1 && m_phase <= 3));
    chk("done", done, (m_phase == 4));
    chk("triggered", triggered, m_trig);
    chk("aborted", aborted, m_abt);
    chk("record_count", record_count, m_cnt);
    chk("trig_index", trig_index, m_tidx);
  endtask

  task automatic tick();
    #1;
    chk("record_ready", record_ready, (!m_ov || out_ready));
    if (out_valid && out_ready) got_q.push_back(out_data);
    model_step();
    @(posedge comm_clock);
    #1;
    check_all();
    if (record_trigger) pulses++;
  endtask

  task automatic quiet_inputs();
    cmd_arm = 0; cmd_abort = 0; cmd_force_trigger = 0;
    record_valid = 0; record_end = 0; out_ready = 1;
  endtask

  task automatic pulse_arm();
    got_q.delete();
    pulses = 0;
    cmd_arm = 1; tick(); cmd_arm = 0;
  endtask

  task automatic pulse_abort();
    cmd_abort = 1; tick(); cmd_abort = 0;
  endtask

  task automatic send(bit rw, logic [31:0] addr, logic [31:0] data);
    record_valid = 1;
    record_out   = rec(rw, addr, data);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_xfer) break;
    end
    chk("send_accepted", last_xfer, 1);
    record_valid = 0;
  endtask

  task automatic wait_done();
    record_end = 1;
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      tick();
    end
    record_end = 0;
    chk("reached_done", done, 1);
  endtask

  task automatic async_reset();
    #2 comm_reset = 1;
    model_reset();
    #1 check_all();
    #1 comm_reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1_addrs[4];
    logic [RW-1:0] rec0, rec1;
    t1_addrs = '{32'h2020FFFF, 32'h12345678, 32'h87654321, 32'h13245768};

    comm_reset = 1;
    quiet_inputs();
    trig_addr = 0; trig_mask = 0; trig_rw = 0; trig_rw_care = 0; post_count = 0;
    record_out = '0;
    model_reset();
    @(posedge comm_clock); #1;
    check_all();
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    comm_reset = 0;

    // Trigger on the third record, one post-trigger record.
    trig_addr = 32'h87654321; trig_mask = 32'hFFFFFFFF; trig_rw_care = 0; post_count = 1;
    pulse_arm();
    chk("t1_start_high", record_start, 1);
    for (int i = 0; i < 4; i++) send(0, t1_addrs[i], 32'(i));
    chk("t1_start_low", record_start, 0);
    wait_done();
    chk("t1_nrec", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t1_order", got_q[i], rec(0, t1_addrs[i], 32'(i)));
    chk("t1_trig_index", trig_index, 2);
    chk("t1_pulses", pulses, 1);
    chk("t1_count", record_count, 4);

    // post_count=0, first record matches.
    trig_mask = 0; post_count = 0;
    pulse_arm();
    send(0, 32'h11110000, 32'h1);
    chk("t2_start_low", record_start, 0);
    chk("t2_trig_index", trig_index, 0);
    chk("t2_triggered", triggered, 1);
    wait_done();

    // Back-pressure for 10 cycles.
    trig_addr = 32'hDEADBEEF; trig_mask = 32'hFFFFFFFF; post_count = 2;
    pulse_arm();
    rec0 = rec(0, 32'hA0, 32'h100);
    rec1 = rec(1, 32'hA1, 32'h101);
    out_ready = 0; record_valid = 1; record_out = rec0;
    tick();
    record_out = rec1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_ready_low", record_ready, 0);
      chk("t3_data_stable", out_data, rec0);
    end
    out_ready = 1;
    send(1, 32'hA1, 32'h101);
    send(0, 32'hA2, 32'h102);
    send(0, 32'hA3, 32'h103);
    tick();
    chk("t3_count", record_count, 4);
    chk("t3_nrec", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("t3_rec0", got_q[0], rec0);
      chk("t3_rec1", got_q[1], rec1);
      chk("t3_rec3", got_q[3], rec(0, 32'hA3, 32'h103));
    end
    pulse_abort();
    wait_done();

    // read_write qualified trigger.
    trig_mask = 0; trig_rw_care = 1; trig_rw = 0; post_count = 5;
    pulse_arm();
    send(1, 32'h1, 32'h0);
    send(1, 32'h2, 32'h0);
    chk("t4_not_yet", triggered, 0);
    send(0, 32'h3, 32'h0);
    chk("t4_triggered", triggered, 1);
    chk("t4_trig_index", trig_index, 2);
    pulse_abort();
    chk("t4_aborted", aborted, 1);
    wait_done();
    trig_rw_care = 0;

    // Abort in ARMED, then arm+abort from DONE.
    trig_addr = 32'hDEADBEEF; trig_mask = 32'hFFFFFFFF; post_count = 3;
    pulse_arm();
    send(0, 32'h10, 32'h0);
    send(0, 32'h20, 32'h0);
    pulse_abort();
    chk("t5_aborted", aborted, 1);
    chk("t5_triggered", triggered, 0);
    chk("t5_count", record_count, 2);
    wait_done();
    cmd_arm = 1; cmd_abort = 1; tick(); cmd_arm = 0; cmd_abort = 0;
    chk("t5_stay_done", done, 1);
    chk("t5_not_busy", busy, 0);

    // Force trigger after one record.
    pulse_arm();
    send(0, 32'h30, 32'h0);
    cmd_force_trigger = 1; tick(); cmd_force_trigger = 0;
    chk("t5f_trig_index", trig_index, 1);
    chk("t5f_pulse", record_trigger, 1);
    pulse_abort();
    wait_done();

    // Async reset while TRIGGERED with a record held.
    trig_addr = 32'h55; post_count = 3;
    pulse_arm();
    send(0, 32'h55, 32'hCAFE);
    out_ready = 0; tick();
    chk("t6_held", out_valid, 1);
    chk("t6_in_trig", record_start, 1);
    #2 comm_reset = 1;
    model_reset();
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_out_data", out_data, 0);
    chk("t6_rst_start", record_start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_triggered", triggered, 0);
    chk("t6_rst_count", record_count, 0);
    check_all();
    #1 comm_reset = 0;
    out_ready = 1;
    post_count = 0;
    pulse_arm();
    send(0, 32'h55, 32'h1);
    chk("t6_rearm_trig", triggered, 1);
    wait_done();

    // Randomized captures.
    for (int n = 0; n < 3000; n++) begin
      quiet_inputs();
      if (m_phase == 0 || m_phase == 4) begin
        trig_addr    = $urandom;
        trig_rw      = 1'($urandom);
        trig_rw_care = 1'($urandom);
        post_count   = CW'($urandom_range(0, 5));
        case ($urandom % 3)
          0: trig_mask = 0;
          1: trig_mask = 32'hFFFFFFFF;
          default: trig_mask = $urandom;
        endcase
        cmd_arm = ($urandom % 6 == 0);
      end else begin
        cmd_arm           = ($urandom % 40 == 0);
        cmd_abort         = ($urandom % 60 == 0);
        cmd_force_trigger = ($urandom % 50 == 0);
      end
      record_valid = !cmd_arm && ($urandom % 4 != 0);
      case ($urandom % 3)
        0: record_out = rec(1'($urandom), trig_addr, $urandom);
        1: record_out = rec(1'($urandom), trig_addr ^ (32'h1 << ($urandom % 32)), $urandom);
        default: record_out = rec(1'($urandom), $urandom, $urandom);
      endcase
      out_ready = ($urandom % 3 != 0);
      if (m_phase == 1 || m_phase == 2)
        record_end = !record_valid && !cmd_abort && !cmd_force_trigger && ($urandom % 30 == 0);
      else
        record_end = ($urandom % 4 == 0);
      if ($urandom % 500 == 0) begin
        quiet_inputs();
        async_reset();
      end else begin
        tick();
      end
    end

    quiet_inputs();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
